// File: rtl/vec_reg_file_masked.sv
// Vector register file: two zero-latency read ports with per-lane write bypass, masked write,
// pending-producer scoreboard, and one-register-per-cycle bulk clear (writes refused while clearing).
module vec_reg_file_masked #(
  parameter int registerSize     = 8,
  parameter int registerQuantity = 8,
  parameter int selectionBits    = 3,
  parameter int vectorSize       = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    regWrEn,
  input  logic [selectionBits-1:0]                regToWrite,
  input  logic [vectorSize-1:0][registerSize-1:0] regWriteData,
  input  logic [vectorSize-1:0]                   laneMask,
  output logic                                    wrReady,
  input  logic [selectionBits-1:0]                rSel1,
  input  logic [selectionBits-1:0]                rSel2,
  output logic [vectorSize-1:0][registerSize-1:0] reg1Out,
  output logic [vectorSize-1:0][registerSize-1:0] reg2Out,
  input  logic                                    reserveEn,
  input  logic [selectionBits-1:0]                reserveSel,
  output logic                                    pend1,
  output logic                                    pend2,
  input  logic                                    clearReq,
  output logic                                    clearBusy,
  output logic                                    clearDone
);

  typedef logic [vectorSize-1:0][registerSize-1:0] vec_t;
  typedef enum logic {IDLE, CLEARING} clrState_t;

  clrState_t                  clrState;
  logic [selectionBits-1:0]   clrIdx;
  logic                       clearing;
  logic                       wrAccept;
  logic                       reserveOk;
  vec_t                       regFlat [registerQuantity];
  logic [registerQuantity-1:0] pending;

  assign clearing  = (clrState == CLEARING);
  assign wrAccept  = regWrEn && wrReady && (int'(regToWrite) < registerQuantity);
  assign reserveOk = reserveEn && !clearBusy && (int'(reserveSel) < registerQuantity);

  // Clear sequencer; status outputs are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clrState  <= IDLE;
      clrIdx    <= '0;
      clearBusy <= 1'b0;
      clearDone <= 1'b0;
      wrReady   <= 1'b1;
    end else begin
      clearDone <= 1'b0;
      case (clrState)
        IDLE: begin
          if (clearReq) begin
            clrState  <= CLEARING;
            clrIdx    <= '0;
            clearBusy <= 1'b1;
            wrReady   <= 1'b0;
          end
        end
        CLEARING: begin
          if (int'(clrIdx) == registerQuantity - 1) begin
            clrState  <= IDLE;
            clearBusy <= 1'b0;
            wrReady   <= 1'b1;
            clearDone <= 1'b1;
          end else begin
            clrIdx <= clrIdx + selectionBits'(1);
          end
        end
        default: clrState <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < registerQuantity; r++) begin : gReg
    vec_t regData;
    logic pendBit;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        regData <= '0;
        pendBit <= 1'b0;
      end else if (clearing && int'(clrIdx) == r) begin
        regData <= '0;
        pendBit <= 1'b0;
      end else begin
        for (int l = 0; l < vectorSize; l++) begin
          if (wrAccept && int'(regToWrite) == r && laneMask[l]) begin
            regData[l] <= regWriteData[l];
          end
        end
        // A same-cycle reserve outranks the completing write.
        if (reserveOk && int'(reserveSel) == r) begin
          pendBit <= 1'b1;
        end else if (wrAccept && int'(regToWrite) == r) begin
          pendBit <= 1'b0;
        end
      end
    end

    assign regFlat[r] = regData;
    assign pending[r] = pendBit;
  end

  always_comb begin
    reg1Out = '0;
    reg2Out = '0;
    pend1   = 1'b0;
    pend2   = 1'b0;
    if (reset) begin
      if (int'(rSel1) < registerQuantity) begin
        reg1Out = regFlat[rSel1];
        pend1   = pending[rSel1];
        for (int l = 0; l < vectorSize; l++) begin
          if (wrAccept && regToWrite == rSel1 && laneMask[l]) begin
            reg1Out[l] = regWriteData[l];
          end
        end
      end
      if (int'(rSel2) < registerQuantity) begin
        reg2Out = regFlat[rSel2];
        pend2   = pending[rSel2];
        for (int l = 0; l < vectorSize; l++) begin
          if (wrAccept && regToWrite == rSel2 && laneMask[l]) begin
            reg2Out[l] = regWriteData[l];
          end
        end
      end
    end
  end

endmodule

// File: doc/vec_reg_file_masked.md
Name: vec_reg_file_masked

Overview:
Next-generation vector register file for the vector datapath. It has two combinational read ports and one write port with a per-lane write mask. Read ports forward same-cycle write data. A pending-write scoreboard tracks long-latency producers, and a bulk-clear sequencer zeroes the file one register per cycle. It sits between decode (read/reserve) and writeback (write/complete).

Parameters:
registerSize, 8, bits per vector element
registerQuantity, 8, number of vector registers
selectionBits, 3, register-select width; equals clog2(registerQuantity)
vectorSize, 4, elements (lanes) per vector register

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
regWrEn  in  1  write request
regToWrite  in  selectionBits  destination register
regWriteData  in  vectorSize x registerSize  write data, packed; element [vectorSize-1] is most significant
laneMask  in  vectorSize  per-lane write enable; bit i gates element i
wrReady  out  1  write port accepting (low while clearing)
rSel1, rSel2  in  selectionBits  read selects
reg1Out, reg2Out  out  vectorSize x registerSize  read data
reserveEn  in  1  mark a register as having an outstanding producer
reserveSel  in  selectionBits  register to reserve
pend1, pend2  out  1  pending bit of rSel1 / rSel2
clearReq  in  1  start bulk clear
clearBusy  out  1  sequencer active
clearDone  out  1  one-cycle pulse when clear completes

Behaviour:
- Reset (reset=0, async):
  - all registers, all pending bits, clearBusy and clearDone go to 0.
  - Sequencer goes to IDLE; wrReady=1.
  - Reads return 0 while reset is held.
- Write:
  - Accepted on a rising edge when regWrEn=1 and wrReady=1.
  - Element i of regToWrite takes regWriteData[i] only where laneMask[i]=1; other lanes hold.
  - laneMask=0 is a legal no-op.
  - An accepted write clears pending[regToWrite], whatever the mask value.
  - regWrEn while wrReady=0 is dropped: no state change.
- Read: combinational, zero latency.
  - Per lane bypass: if an accepted write targets the selected register and laneMask[i]=1, element i shows regWriteData[i] in the same cycle.
  - All other lanes show stored data.
  - Both ports may select the same register.
- Scoreboard:
  - reserveEn sets pending[reserveSel] at the edge.
  - If reserve and accepted write target the same register in one cycle, the reserve wins and pending stays 1.
  - pend1/pend2 are combinational from the stored pending bits; there is no bypass of reserve.
  - reserveEn is ignored while clearBusy=1.
- Clear sequencer, states IDLE and CLEARING, with index counter clrIdx.
  - IDLE, clearReq=1 at edge: go to CLEARING with clrIdx=0; clearBusy=1 and wrReady=0 from the next cycle.
  - Each CLEARING edge: register clrIdx and pending[clrIdx] become 0, then clrIdx increments.
  - On the edge that clears registerQuantity-1: go to IDLE; clearBusy=0, wrReady=1; clearDone=1 for exactly one cycle.
  - clearBusy is high for exactly registerQuantity cycles.
  - clearReq while CLEARING is ignored.
  - Reads stay serviced during a clear and show the stored value, which is 0 once that index is cleared. Clear writes are not bypassed.
  - Reset mid-clear: immediate IDLE; everything is zeroed by reset itself.
- Width rules: rSel/regToWrite/reserveSel values >= registerQuantity are not driven by users. Reads of such a value return 0; writes and reserves to it are ignored.

Test Plan:
1. Reset low 2 cycles, then high -> all reg1Out/reg2Out = 0, pend1=pend2=0, wrReady=1, clearBusy=0.
2. Full write reg1=32'hDEADBEEF, mask 4'b1111. Next cycle masked write reg1=32'h11223344, mask 4'b0101 -> rSel1=1 reads 32'hDE22BE44; rSel2=0 reads 0.
3. Bypass: write reg3=32'h1A2B3C4D, mask 4'b0011, with rSel1=3 in the same cycle before the edge -> reg1Out=32'h00003C4D combinationally; after the edge it still reads the same.
4. Scoreboard: reserve reg5 -> pend1=1 with rSel1=5. Then reserve reg5 and write reg5 in the same cycle -> pend1 stays 1. Then write reg5 alone -> pend1=0.
5. Clear: preload reg1, reg3 and reg7, reserve reg2, pulse clearReq.
   - clearBusy=1 and wrReady=0 for 8 cycles; a write of 32'hFFFFFFFF to reg4 during the clear is dropped.
   - clearDone pulses once; all registers read 0; pend=0 for reg2.
   - A second clearReq issued mid-clear has no effect.
6. Reset asserted in cycle 3 of a clear -> clearBusy=0 immediately, no clearDone pulse, all registers 0. A write after deassertion succeeds.
